spart_tx_engine: RTL and testbench

Serial transmit half of the SPART: serialises bytes from the processor-side bus onto `txd` as 8N1 asynchronous frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). It mirrors the existing SPART receive path and sits between the CPU's memory-mapped SPART registers and the board's UART `txd` pin. The default bit time is 2604 clocks, which is 38400 baud at 100 MHz, matching the receive side. A one-byte holding register lets software queue the next byte while the current one shifts.

---
 rtl/spart_tx_engine.sv | 132 +++++++++++++
 tb/tb_spart_tx_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_tx_engine.sv
// spart_tx_engine: 8N1 serial transmitter with a one-byte holding register
// and a programmable bit-time divisor, mirroring the SPART receive path.
module spart_tx_engine #(
  parameter logic [15:0] DIVISOR_DEFAULT = 16'd2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_wr,
  input  logic [15:0] div_data,
  input  logic        div_wr,
  output logic        txd,
  output logic        tbr,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_ovr
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [7:0]  hold;
  logic        hold_v;
  logic [9:0]  frame;
  logic [15:0] div_reg;
  logic [15:0] div_act;
  logic [15:0] cnt;
  logic [3:0]  idx;
  logic        load;

  // The line pin is the LSB of the shift frame, so it always comes straight from a flop.
  assign txd  = frame[0];
  assign tbr  = ~hold_v;
  // A waiting byte moves into the shifter when the line is idle or a stop bit is finishing.
  assign load = hold_v && ((state == IDLE) || ((state == STOP) && (cnt == 16'd0)));

  // Holding register: accept writes only when empty, flag rejected writes one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= 8'h00;
      hold_v <= 1'b0;
      tx_ovr <= 1'b0;
    end else begin
      tx_ovr <= tx_wr & hold_v;
      if (tx_wr && !hold_v) begin
        hold   <= tx_data;
        hold_v <= 1'b1;
      end else if (load) begin
        hold_v <= 1'b0;
      end
    end
  end

  // Programmed divisor; 0 and 1 would give degenerate bits, so they become 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= DIVISOR_DEFAULT;
    end else if (div_wr) begin
      div_reg <= (div_data < 16'd2) ? 16'd2 : div_data;
    end
  end

  // Frame sequencer: start, eight data bits, stop, each div_act cycles long.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      frame   <= '1;
      div_act <= DIVISOR_DEFAULT;
      cnt     <= 16'd0;
      idx     <= 4'd0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            state   <= START;
            frame   <= {1'b1, hold, 1'b0};
            div_act <= div_reg;
            cnt     <= div_reg - 16'd1;
            idx     <= 4'd0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == 16'd0) begin
            state <= DATA;
            idx   <= 4'd0;
            cnt   <= div_act - 16'd1;
            frame <= {1'b1, frame[9:1]};
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (cnt == 16'd0) begin
            cnt   <= div_act - 16'd1;
            frame <= {1'b1, frame[9:1]};
            if (idx == 4'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (cnt == 16'd0) begin
            if (load) begin
              state   <= START;
              frame   <= {1'b1, hold, 1'b0};
              div_act <= div_reg;
              cnt     <= div_reg - 16'd1;
              idx     <= 4'd0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            if (cnt == 16'd1) begin
              tx_done <= 1'b1;
            end
            cnt <= cnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_tx_engine.sv
// tb_spart_tx_engine: directed stimulus for spart_tx_engine, checked every cycle
// against a frame-timeline model plus hand-computed literal expectations.
module tb_spart_tx_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_wr = 1'b0;
  logic [15:0] div_data = 16'h0000;
  logic        div_wr = 1'b0;
  logic        txd, tbr, tx_busy, tx_done, tx_ovr;

  int checks = 0;
  int fails = 0;

  spart_tx_engine #(.DIVISOR_DEFAULT(16'd2604)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_wr(tx_wr),
    .div_data(div_data), .div_wr(div_wr), .txd(txd), .tbr(tbr),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_ovr(tx_ovr)
  );

  always #5 clk = ~clk;

  // Model: a frame is a start cycle fs and bit time d; cycle n lies in bit (n-fs)/d.
  int          cyc = 0;
  bit          m_valid = 0;
  logic        m_hold_v = 1'b0;
  logic [7:0]  m_hold = 8'h00;
  int          m_div_reg = 2604;
  bit          m_active = 0;
  int          m_fs = 0;
  int          m_d = 0;
  logic [7:0]  m_byte = 8'h00;
  logic        m_ovr = 1'b0;
  int          done_q[$];
  int          ovr_q[$];

  // Model update on each edge: cycle n is the cycle following edge n.
  always @(posedge clk) begin
    logic hv;
    cyc++;
    if (rst) begin
      m_valid   = 1;
      m_hold_v  = 1'b0;
      m_active  = 0;
      m_div_reg = 2604;
      m_ovr     = 1'b0;
    end else begin
      hv    = m_hold_v;
      m_ovr = tx_wr && hv;
      if (m_active && (cyc >= m_fs + 10 * m_d)) m_active = 0;
      if (!m_active && hv) begin
        m_active = 1;
        m_fs     = cyc;
        m_d      = m_div_reg;
        m_byte   = m_hold;
        m_hold_v = 1'b0;
      end
      if (tx_wr && !hv) begin
        m_hold   = tx_data;
        m_hold_v = 1'b1;
      end
      if (div_wr) m_div_reg = (div_data < 16'd2) ? 2 : int'(div_data);
    end
  end

  function automatic logic exp_txd();
    int k;
    if (!m_active) return 1'b1;
    k = (cyc - m_fs) / m_d;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  // Per-cycle comparison of all outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [4:0] exp_v;
    logic [4:0] act_v;
    if (m_valid) begin
      exp_v = {exp_txd(), ~m_hold_v, logic'(m_active),
               logic'(m_active && (cyc == m_fs + 10 * m_d - 1)), m_ovr};
      act_v = {txd, tbr, tx_busy, tx_done, tx_ovr};
      checks++;
      if (act_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL cycle_outputs cyc=%0d {txd,tbr,busy,done,ovr} got %b expected %b",
                 cyc, act_v, exp_v);
      end
    end
    if (tx_done === 1'b1) done_q.push_back(cyc);
    if (tx_ovr === 1'b1) ovr_q.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] data,
                               input logic dwr, input logic [15:0] ddata);
    tx_wr = wr; tx_data = data; div_wr = dwr; div_data = ddata;
    tick(1);
    tx_wr = 1'b0; div_wr = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s cyc=%0d got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic waitTbr(input int limit);
    int n;
    n = 0;
    while (tbr !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput("tbr_wait", 32'(tbr), 1);
  endtask

  // Guard against a stuck run.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c, c2, c3, s, nd, no;
    logic [9:0] pat;

    tick(3);
    checkOutput("reset_txd", 32'(txd), 1);
    checkOutput("reset_tbr", 32'(tbr), 1);
    checkOutput("reset_busy", 32'(tx_busy), 0);
    checkOutput("reset_done", 32'(tx_done), 0);
    checkOutput("reset_ovr", 32'(tx_ovr), 0);
    rst = 1'b0;
    tick(2);

    $display("[TB] 0x55 with divisor 4 written in the same cycle");
    c = cyc;
    applyStimulus(1'b1, 8'h55, 1'b1, 16'd4);
    checkOutput("t1_tbr_e1", 32'(tbr), 0);
    tick(1);
    checkOutput("t1_txd_e2", 32'(txd), 0);
    checkOutput("t1_tbr_e2", 32'(tbr), 1);
    checkOutput("t1_busy_e2", 32'(tx_busy), 1);
    pat = 10'b1010101010;
    for (int k = 0; k < 10; k++) begin
      waitUntil(c + 2 + 4 * k + 1);
      checkOutput("t1_bit", 32'(txd), 32'(pat[k]));
    end
    waitUntil(c + 2 + 39);
    checkOutput("t1_done", 32'(tx_done), 1);
    tick(1);
    checkOutput("t1_busy_fall", 32'(tx_busy), 0);

    $display("[TB] back-to-back 0x01 then 0xFF");
    tick(2);
    nd = done_q.size(); no = ovr_q.size();
    c = cyc;
    applyStimulus(1'b1, 8'h01, 1'b0, 16'd0);
    waitTbr(20);
    applyStimulus(1'b1, 8'hFF, 1'b0, 16'd0);
    waitUntil(c + 2 + 80 + 2);
    checkOutput("t2_done_count", 32'(done_q.size() - nd), 2);
    checkOutput("t2_ovr_count", 32'(ovr_q.size() - no), 0);
    if (done_q.size() >= nd + 2) begin
      checkOutput("t2_done1_cycle", 32'(done_q[nd]), 32'(c + 41));
      checkOutput("t2_done_gap", 32'(done_q[nd+1] - done_q[nd]), 40);
    end

    $display("[TB] three writes, third rejected");
    tick(2);
    nd = done_q.size(); no = ovr_q.size();
    c = cyc;
    applyStimulus(1'b1, 8'hC5, 1'b0, 16'd0);
    tick(1);
    applyStimulus(1'b1, 8'h3A, 1'b0, 16'd0);
    applyStimulus(1'b1, 8'h00, 1'b0, 16'd0);
    checkOutput("t3_ovr_pulse", 32'(tx_ovr), 1);
    waitUntil(c + 2 + 80 + 2);
    checkOutput("t3_done_count", 32'(done_q.size() - nd), 2);
    checkOutput("t3_ovr_count", 32'(ovr_q.size() - no), 1);
    if (ovr_q.size() > no) checkOutput("t3_ovr_cycle", 32'(ovr_q[no]), 32'(c + 4));

    $display("[TB] divisor 8 mid-frame, then clamp of 0");
    tick(2);
    nd = done_q.size();
    c = cyc;
    applyStimulus(1'b1, 8'h3C, 1'b0, 16'd0);
    waitUntil(c + 12);
    applyStimulus(1'b0, 8'h00, 1'b1, 16'd8);
    waitUntil(c + 2 + 40 + 1);
    c2 = cyc;
    applyStimulus(1'b1, 8'hC3, 1'b0, 16'd0);
    waitUntil(c2 + 2 + 80 + 1);
    c3 = cyc;
    applyStimulus(1'b1, 8'h96, 1'b1, 16'd0);
    waitUntil(c3 + 2 + 20 + 1);
    checkOutput("t4_done_count", 32'(done_q.size() - nd), 3);
    if (done_q.size() >= nd + 3) begin
      checkOutput("t4_div4_done", 32'(done_q[nd]), 32'(c + 41));
      checkOutput("t4_div8_done", 32'(done_q[nd+1]), 32'(c2 + 81));
      checkOutput("t4_div2_done", 32'(done_q[nd+2]), 32'(c3 + 21));
    end

    $display("[TB] reset during data bit 3 with a byte queued");
    tick(2);
    c = cyc;
    applyStimulus(1'b1, 8'hA5, 1'b1, 16'd4);
    tick(1);
    applyStimulus(1'b1, 8'h77, 1'b0, 16'd0);
    waitUntil(c + 2 + 17);
    checkOutput("t5_bit3_low", 32'(txd), 0);
    nd = done_q.size();
    rst = 1'b1;
    tick(1);
    checkOutput("t5_txd", 32'(txd), 1);
    checkOutput("t5_tbr", 32'(tbr), 1);
    checkOutput("t5_busy", 32'(tx_busy), 0);
    checkOutput("t5_done", 32'(tx_done), 0);
    rst = 1'b0;
    tick(6);
    checkOutput("t5_no_done", 32'(done_q.size() - nd), 0);
    checkOutput("t5_discarded", 32'(tx_busy), 0);

    $display("[TB] default divisor, 0xA3");
    nd = done_q.size();
    c = cyc;
    applyStimulus(1'b1, 8'hA3, 1'b0, 16'd0);
    s = c + 2;
    pat = 10'b1101000110;
    for (int k = 0; k < 10; k++) begin
      waitUntil(s + 2604 * k + 1302);
      checkOutput("t6_bit", 32'(txd), 32'(pat[k]));
    end
    waitUntil(s + 2603);
    waitUntil(s + 26039);
    checkOutput("t6_done", 32'(tx_done), 1);
    tick(1);
    checkOutput("t6_busy_fall", 32'(tx_busy), 0);
    checkOutput("t6_done_count", 32'(done_q.size() - nd), 1);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
